spm_host: RTL
=============

Name: spm_host

Overview:
- Initiator-side sequencer for the 8x8 signed serial-parallel multiplier, which uses a start/done protocol.
- Accepts operand pairs on a valid/ready command channel and holds the operands on the multiplier inputs.
- Issues a one-cycle start pulse, waits for done with a timeout, captures the 16-bit product and returns it on a valid/ready response channel.
- Sits between a command source (CPU/bus bridge) and the multiplier/ALU datapath.

Parameters:
- TIMEOUT_CYCLES, 64: max WAIT cycles without spm_done_i before the operation is aborted; legal range 2..1023.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): timeout counter width; derived, not overridden.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  host can accept a command
- cmd_a_i  in  8  multiplicand, signed two's complement
- cmd_b_i  in  8  multiplier, signed two's complement
- spm_start_o  out  1  one-cycle start pulse to the multiplier
- spm_a_o  out  8  operand A to the multiplier
- spm_b_o  out  8  operand B to the multiplier
- spm_done_i  in  1  multiplier done (level or pulse)
- spm_prod_i  in  16  multiplier product
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  consumer accepts the response
- rsp_prod_o  out  16  captured product; 0 on timeout
- rsp_timeout_o  out  1  response is a timeout abort
- rsp_mismatch_o  out  1  product check failed (see Optional Feature)
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, operand registers 0. Asserting rst_i mid-operation aborts immediately; no response is produced for the aborted command.
- All outputs are registered except cmd_ready_o and busy_o, which decode state.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i && cmd_ready_o: latch cmd_a_i/cmd_b_i into spm_a_o/spm_b_o, go to LAUNCH.
  - spm_done_i is ignored.
- LAUNCH: lasts exactly 1 cycle.
  - spm_start_o = 1 in this cycle only.
  - Counter cleared to 0.
  - spm_done_i is ignored in this cycle.
  - Next state is WAIT.
- WAIT:
  - If spm_done_i = 1: capture spm_prod_i into rsp_prod_o, set rsp_timeout_o = 0, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: set rsp_prod_o = 0, rsp_timeout_o = 1, go to RESP.
  - Else: increment counter.
  - If done and timeout coincide, done wins.
- RESP:
  - rsp_valid_o = 1.
  - rsp_prod_o, rsp_timeout_o and rsp_mismatch_o are held stable while rsp_valid_o && !rsp_ready_i.
  - On rsp_ready_i: clear rsp_valid_o, go to IDLE.
  - cmd_ready_o returns to 1 the cycle after the response handshake.
  - Spurious spm_done_i is ignored.
- spm_a_o/spm_b_o hold from acceptance until the next accepted command; they are not cleared after a response.
- Single outstanding command; no pipelining.
- Minimum command-to-response latency: accept at cycle T, start at T+1, done sampled no earlier than T+2, rsp_valid_o at T+3.
- rsp_ready_i held high while no response is pending has no effect.

Optional Feature:
- Macro: SPM_HOST_CHECK_EN
- Defined: at capture, compute $signed(spm_a_o)*$signed(spm_b_o) (16-bit) and register rsp_mismatch_o = (product != spm_prod_i). rsp_mismatch_o = 0 on timeout responses. Adds no latency.
- Undefined: rsp_mismatch_o is tied to 0 and no multiplier logic is synthesized.

Test Plan:
- Basic: A=0xFD (-3), B=0x05, multiplier model returns done after 8 cycles → spm_start_o pulses once at T+1; rsp_prod_o=0xFFF1, rsp_timeout_o=0, rsp_mismatch_o=0.
- Corner operands: A=0x80, B=0x80 → rsp_prod_o=0x4000. A=0x7F, B=0x80 → 0xC080. A=0x00, B=0xFF → 0x0000.
- Timeout: TIMEOUT_CYCLES=64, spm_done_i never asserted; accept at T → rsp_valid_o rises at T+66, rsp_prod_o=0, rsp_timeout_o=1. Done at the final WAIT cycle (T+65) → normal response, rsp_timeout_o=0.
- Backpressure: rsp_ready_i low for 5 cycles → rsp_* stable, cmd_ready_o=0, busy_o=1, second cmd_valid_i not accepted; accepted one cycle after the response handshake.
- Reset mid-WAIT: assert rst_i 3 cycles after start → all outputs 0 asynchronously, state IDLE, no response emitted; next command completes normally.
- Check (SPM_HOST_CHECK_EN defined): model returns 0x1234 for A=0x02, B=0x03 → rsp_mismatch_o=1. Correct 0x0006 → rsp_mismatch_o=0. Macro undefined → rsp_mismatch_o=0 in both cases.

Source files
------------

// File: rtl/spm_host_if.sv
// Command, multiplier and response signals of the spm_host sequencer.
// The slave modport is the host's view. The master modport is the view of the environment around it.
interface spm_host_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [7:0]  cmd_a_i;
  logic [7:0]  cmd_b_i;
  logic        spm_start_o;
  logic [7:0]  spm_a_o;
  logic [7:0]  spm_b_o;
  logic        spm_done_i;
  logic [15:0] spm_prod_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [15:0] rsp_prod_o;
  logic        rsp_timeout_o;
  logic        rsp_mismatch_o;
  logic        busy_o;

  modport slave (
    input  cmd_valid_i, cmd_a_i, cmd_b_i, spm_done_i, spm_prod_i, rsp_ready_i,
    output cmd_ready_o, spm_start_o, spm_a_o, spm_b_o,
           rsp_valid_o, rsp_prod_o, rsp_timeout_o, rsp_mismatch_o, busy_o
  );

  modport master (
    output cmd_valid_i, cmd_a_i, cmd_b_i, spm_done_i, spm_prod_i, rsp_ready_i,
    input  cmd_ready_o, spm_start_o, spm_a_o, spm_b_o,
           rsp_valid_o, rsp_prod_o, rsp_timeout_o, rsp_mismatch_o, busy_o
  );
endinterface

// File: rtl/spm_host.sv
// spm_host: start/done sequencer for the 8x8 signed serial-parallel multiplier, with a WAIT timeout.
// Defining SPM_HOST_CHECK_EN adds a product self-check on rsp_mismatch_o. Without it, rsp_mismatch_o is 0.
module spm_host #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  spm_host_if.slave  bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             cnt_last;

  assign accept          = (state_q == S_IDLE) && bus.cmd_valid_i;
  assign cnt_last        = (cnt_q == CNT_LAST);
  assign bus.cmd_ready_o = (state_q == S_IDLE);
  assign bus.busy_o      = (state_q != S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.cmd_valid_i) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (bus.spm_done_i || cnt_last) state_d = S_RESP;
      S_RESP:   if (bus.rsp_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // In WAIT, done takes priority over an expiring counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q             <= '0;
      bus.spm_start_o   <= 1'b0;
      bus.spm_a_o       <= '0;
      bus.spm_b_o       <= '0;
      bus.rsp_valid_o   <= 1'b0;
      bus.rsp_prod_o    <= '0;
      bus.rsp_timeout_o <= 1'b0;
    end else begin
      bus.spm_start_o <= accept;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid_i) begin
            bus.spm_a_o <= bus.cmd_a_i;
            bus.spm_b_o <= bus.cmd_b_i;
          end
        end
        S_LAUNCH: cnt_q <= '0;
        S_WAIT: begin
          if (bus.spm_done_i) begin
            bus.rsp_prod_o    <= bus.spm_prod_i;
            bus.rsp_timeout_o <= 1'b0;
            bus.rsp_valid_o   <= 1'b1;
          end else if (cnt_last) begin
            bus.rsp_prod_o    <= '0;
            bus.rsp_timeout_o <= 1'b1;
            bus.rsp_valid_o   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: if (bus.rsp_ready_i) bus.rsp_valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef SPM_HOST_CHECK_EN
  logic signed [15:0] a_ext, b_ext, exp_prod;
  assign a_ext    = 16'($signed(bus.spm_a_o));
  assign b_ext    = 16'($signed(bus.spm_b_o));
  assign exp_prod = a_ext * b_ext;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.rsp_mismatch_o <= 1'b0;
    end else if (state_q == S_WAIT) begin
      if (bus.spm_done_i)  bus.rsp_mismatch_o <= (exp_prod != bus.spm_prod_i);
      else if (cnt_last)   bus.rsp_mismatch_o <= 1'b0;
    end
  end
`else
  assign bus.rsp_mismatch_o = 1'b0;
`endif

endmodule
